// File: rtl/mem4x4_pkg.sv
// mem4x4 command sequencer: shared op codes, FSM states and default widths.
// Imported by the sequencer and its bench.
package mem4x4_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SCAN  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAP,
        SCAN,
        RESP
    } state_t;

endpackage

// File: rtl/mem4x4_ctrl_if.sv
// Command/response handshake bundle between a requester and mem4x4_ctrl.
// The master issues commands and consumes responses; the slave sequences them.
interface mem4x4_ctrl_if #(
    parameter int DW = mem4x4_pkg::DW_DEF,
    parameter int AW = mem4x4_pkg::AW_DEF
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/mem4x4_ctrl.sv
// Sequencer owning the pins of a small synchronous RAM: READ, WRITE and
// SCAN (XOR checksum of every word), one response per command.
module mem4x4_ctrl
    import mem4x4_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem4x4_ctrl_if.slave  bus,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    localparam int CW = AW + 1;
    // Scan counter reaches this in the cycle after the last address.
    localparam logic [CW-1:0] SCAN_LAST = {1'b1, {AW{1'b0}}};

    state_t        state;
    state_t        state_nx;
    logic          accept;
    logic          rsvd;
    logic          rsvd_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_din_nx;
    logic          mem_we_nx;
    logic [DW-1:0] rsp_data_q;
    logic [DW-1:0] rsp_data_nx;
    logic          rsp_err_q;
    logic          rsp_err_nx;

    assign bus.rsp_valid = !rst && (state == RESP);
    assign bus.cmd_ready = !rst && (state == IDLE) && !bus.rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        bus.cmd_op == OP_WRITE: state_nx = WR;
                        bus.cmd_op == OP_SCAN:  state_nx = SCAN;
                        default:                state_nx = RD_ISSUE;
                    endcase
                end
            end
            WR:       state_nx = RESP;
            RD_ISSUE: state_nx = rsvd ? RESP : RD_CAP;
            RD_CAP:   state_nx = RESP;
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_nx = mem_addr;
        mem_din_nx  = mem_din;
        mem_we_nx   = 1'b0;
        rsp_data_nx = rsp_data_q;
        rsp_err_nx  = rsp_err_q;
        acc_nx      = acc;
        cnt_nx      = cnt;
        rsvd_nx     = rsvd;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    rsp_err_nx = 1'b0;
                    rsvd_nx    = 1'b0;
                    unique case (1'b1)
                        bus.cmd_op == OP_WRITE: begin
                            mem_addr_nx = bus.cmd_addr;
                            mem_din_nx  = bus.cmd_data;
                            mem_we_nx   = 1'b1;
                        end
                        bus.cmd_op == OP_SCAN: begin
                            mem_addr_nx = '0;
                            acc_nx      = '0;
                            cnt_nx      = '0;
                        end
                        bus.cmd_op == OP_RSVD: begin
                            rsvd_nx = 1'b1;
                        end
                        default: begin
                            mem_addr_nx = bus.cmd_addr;
                        end
                    endcase
                end
            end
            WR: begin
                rsp_data_nx = mem_din;
            end
            RD_ISSUE: begin
                if (rsvd) begin
                    rsp_data_nx = '0;
                    rsp_err_nx  = 1'b1;
                end
            end
            RD_CAP: begin
                rsp_data_nx = mem_dout;
            end
            SCAN: begin
                cnt_nx = cnt + 1'b1;
                // Read data trails the address by one cycle.
                if (cnt != '0) begin
                    acc_nx = acc ^ mem_dout;
                end
                if (cnt < SCAN_LAST - 1'b1) begin
                    mem_addr_nx = mem_addr + 1'b1;
                end
                if (cnt == SCAN_LAST) begin
                    rsp_data_nx = acc ^ mem_dout;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            rsvd       <= 1'b0;
        end else begin
            mem_addr   <= mem_addr_nx;
            mem_din    <= mem_din_nx;
            mem_we     <= mem_we_nx;
            rsp_data_q <= rsp_data_nx;
            rsp_err_q  <= rsp_err_nx;
            acc        <= acc_nx;
            cnt        <= cnt_nx;
            rsvd       <= rsvd_nx;
        end
    end

endmodule

// File: tb/tb_mem4x4_ctrl.sv
// Bench for mem4x4_ctrl: directed plan plus random commands against a
// word-array reference model; a behavioural RAM sits on the memory pins.
module tb_mem4x4_ctrl;
    import mem4x4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mem_addr;
    logic [3:0] mem_din;
    logic [3:0] mem_dout;
    logic       mem_we;

    logic [3:0] ram [4];
    logic [3:0] pre_val [4];
    logic       pre_en;
    logic [3:0] ref_mem [4];

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int lat;
    logic [1:0] addr_log [32];
    logic       we_log [32];

    always #5 clk = ~clk;

    mem4x4_ctrl_if bus ();

    mem4x4_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 4; i++) ram[i] <= pre_val[i];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        mem_dout <= ram[mem_addr];
    end

    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected response as err*16 + data; applies WRITE to the model.
    function automatic int model(input logic [1:0] op, input logic [1:0] a,
                                 input logic [3:0] d);
        int x = 0;
        case (op)
            OP_READ:  return int'(ref_mem[a]);
            OP_WRITE: begin
                ref_mem[a] = d;
                return int'(d);
            end
            OP_SCAN: begin
                for (int i = 0; i < 4; i++) x = x ^ int'(ref_mem[i]);
                return x;
            end
            default:  return 16;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            OP_READ:  return 3;
            OP_SCAN:  return 6;
            default:  return 2;
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [1:0] a,
                         input logic [3:0] d);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = 2'($urandom);
        bus.cmd_data  = 4'($urandom);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] a,
                          input logic [3:0] d, input int stall);
        int e;
        int we0;
        logic [1:0] p_addr;
        e = model(op, a, d);
        we0 = we_cnt;
        p_addr = mem_addr;
        bus.rsp_ready = (stall == 0);
        issue(op, a, d);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            addr_log[lat] = mem_addr;
            we_log[lat]   = mem_we;
            tick();
            lat++;
        end
        check("latency", lat, exp_lat(op));
        check("rsp_data", int'(bus.rsp_data), e & 15);
        check("rsp_err", int'(bus.rsp_err), e >> 4);
        if (op == OP_WRITE) begin
            check("wr_we_cycle1", int'(we_log[1]), 1);
            check("wr_addr_cycle1", int'(addr_log[1]), int'(a));
        end else if (op == OP_READ) begin
            check("rd_addr_cycle1", int'(addr_log[1]), int'(a));
        end else if (op == OP_SCAN) begin
            for (int k = 1; k <= 4; k++)
                check("scan_addr", int'(addr_log[k]), k - 1);
        end else begin
            check("rsvd_addr_held", int'(addr_log[1]), int'(p_addr));
        end
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_WRITE;
            end
            tick();
            bus.cmd_valid = 1'b0;
            check("stall_valid", int'(bus.rsp_valid), 1);
            check("stall_data", int'(bus.rsp_data), e & 15);
            check("stall_ready", int'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("we_count", we_cnt - we0, (op == OP_WRITE) ? 1 : 0);
        check("idle_ready", int'(bus.cmd_ready), 1);
    endtask

    initial begin
        logic [1:0] op;
        rst           = 1'b1;
        pre_en        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_READ;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        pre_val = '{4'b1010, 4'b1110, 4'b0110, 4'b1111};
        ref_mem = '{4'b1010, 4'b1110, 4'b0110, 4'b1111};
        tick();
        tick();
        check("rst_cmd_ready", int'(bus.cmd_ready), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_din", int'(mem_din), 0);
        check("rst_rsp_data", int'(bus.rsp_data), 0);
        check("rst_rsp_err", int'(bus.rsp_err), 0);
        pre_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("first_idle_ready", int'(bus.cmd_ready), 1);

        do_cmd(OP_READ, 2'd2, 4'd0, 0);
        do_cmd(OP_SCAN, 2'd0, 4'd0, 0);
        do_cmd(OP_WRITE, 2'd1, 4'b0101, 0);
        do_cmd(OP_READ, 2'd1, 4'd0, 0);
        do_cmd(OP_SCAN, 2'd3, 4'd9, 0);
        do_cmd(OP_READ, 2'd3, 4'd0, 5);
        do_cmd(OP_RSVD, 2'd2, 4'd7, 0);

        issue(OP_SCAN, 2'd0, 4'd0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
        check("midrst_mem_we", int'(mem_we), 0);
        rst = 1'b0;
        #1;
        check("midrst_idle_ready", int'(bus.cmd_ready), 1);
        do_cmd(OP_READ, 2'd0, 4'd0, 0);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            do_cmd(op, 2'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
